axis_pixel_gen: RTL and testbench

AXIS_PIXEL_GEN -- requirements
Module: axis_pixel_gen

---
 rtl/axis_pixel_gen_pkg.sv | 26 ++
 rtl/axis_pixel_gen_if.sv | 35 +++
 rtl/axis_xy_counter.sv | 87 ++++++++
 rtl/axis_pixel_gen.sv | 152 +++++++++++++++
 tb/tb_axis_pixel_gen.sv | 370 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axis_pixel_gen_pkg.sv
// -----------------------------------------------------------------------------
// axis_pixel_gen_pkg
//   Shared definitions for the AXI-Stream test-pattern pixel generator:
//   FSM state encoding, tlast placement modes and a helper that sizes the
//   x/y counters.
//   No ports (package).
// -----------------------------------------------------------------------------
package axis_pixel_gen_pkg;

  // Generator state: waiting for a frame base value, or emitting a frame.
  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } state_e;

  // tlast placement.
  localparam int TLAST_FRAME = 0;  // tlast on the last pixel of the frame
  localparam int TLAST_ROW   = 1;  // tlast on the last pixel of every row

  // Counter width for a dimension of n elements; never narrower than 1 bit so
  // a 1-pixel dimension still yields a legal vector.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage : axis_pixel_gen_pkg

// File: rtl/axis_pixel_gen_if.sv
// -----------------------------------------------------------------------------
// axis_pixel_gen_if
//   One AXI-Stream channel (tdata/tvalid/tready/tlast/tuser).
//   Modports:
//     master : drives tdata, tvalid, tlast, tuser; samples tready
//     slave  : samples tdata, tvalid, tlast, tuser; drives tready
//   Parameter DATA_WIDTH sets the width of tdata.
// -----------------------------------------------------------------------------
interface axis_pixel_gen_if #(
  parameter int DATA_WIDTH = 32
) ();

  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;
  logic                  tuser;

  modport master (
    output tdata,
    output tvalid,
    output tlast,
    output tuser,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    input  tlast,
    input  tuser,
    output tready
  );

endinterface : axis_pixel_gen_if

// File: rtl/axis_xy_counter.sv
// -----------------------------------------------------------------------------
// axis_xy_counter
//   Raster x/y position counter for a WIDTH x HEIGHT frame. x runs fastest;
//   when x reaches WIDTH-1 it wraps to 0 and y increments (y wraps after
//   HEIGHT-1). The position always names the pixel currently on the output.
//   Ports:
//     ACLK, aresetn   : clock, synchronous active-low reset (position -> 0,0)
//     clear           : restart at (0,0) (has priority over en)
//     en              : step to the next pixel
//     row_end         : current pixel is the last of its row
//     frame_end       : current pixel is the last of the frame
//     row_end_nxt     : the pixel after the current one is the last of a row
//     frame_end_nxt   : the pixel after the current one ends the frame
//   The *_nxt flags let the parent register tlast for the following pixel in
//   the same cycle it advances, so its outputs stay purely registered.
// -----------------------------------------------------------------------------
module axis_xy_counter
  import axis_pixel_gen_pkg::*;
#(
  parameter int WIDTH  = 20,
  parameter int HEIGHT = 20
) (
  input  logic ACLK,
  input  logic aresetn,
  input  logic clear,
  input  logic en,
  output logic row_end,
  output logic frame_end,
  output logic row_end_nxt,
  output logic frame_end_nxt
);

  localparam int XW = cnt_width(WIDTH);
  localparam int YW = cnt_width(HEIGHT);

  localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
  localparam logic [XW-1:0] X_PEN  = XW'((WIDTH >= 2) ? WIDTH - 2 : 0);
  localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);
  localparam logic [YW-1:0] Y_PEN  = YW'((HEIGHT >= 2) ? HEIGHT - 2 : 0);

  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic          last_row_nxt;

  // NOTE: every variable written in an always_comb gets a default on entry;
  // a path that leaves one unassigned would infer a latch.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (clear) begin
      x_d = '0;
      y_d = '0;
    end else if (en) begin
      if (x_q == X_LAST) begin
        x_d = '0;
        y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  // NOTE: clocked state is written with non-blocking assignments so every
  // flop samples the pre-edge value of its neighbours, as the hardware does.
  always_ff @(posedge ACLK) begin
    if (!aresetn) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign row_end   = (x_q == X_LAST);
  assign frame_end = row_end && (y_q == Y_LAST);

  // A 1-pixel-wide frame has every pixel at a row end. Otherwise the next
  // pixel closes a row only if the current one is the second-to-last.
  assign row_end_nxt = (WIDTH == 1) || (x_q == X_PEN);

  // Row of the next pixel: moves down one when the current pixel ends a row.
  assign last_row_nxt  = row_end ? ((HEIGHT >= 2) && (y_q == Y_PEN))
                                 : (y_q == Y_LAST);
  assign frame_end_nxt = row_end_nxt && last_row_nxt;

endmodule : axis_xy_counter

// File: rtl/axis_pixel_gen.sv
// -----------------------------------------------------------------------------
// axis_pixel_gen
//   Frame generator. Accepts one base value on the slave stream, then emits a
//   WIDTH x HEIGHT frame on the master stream where pixel (x,y) carries
//   base + y*WIDTH + x (wrapping modulo 2^DATA_WIDTH). Raster order makes that
//   a plain +1 per beat, so the value is kept in a running adder.
//   Ports:
//     ACLK, aresetn : clock, synchronous active-low reset
//     s_axis        : slave stream; tdata = frame base, tlast/tuser ignored,
//                     tready high only while idle
//     m_axis        : master stream of pixels; tuser marks pixel (0,0), tlast
//                     marks the frame end (TLAST_FRAME) or each row end
//                     (TLAST_ROW)
//     frame_done    : one-cycle pulse the cycle after the last pixel handshake
//   All outputs come straight from flops.
// -----------------------------------------------------------------------------
module axis_pixel_gen
  import axis_pixel_gen_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int WIDTH      = 20,
  parameter int HEIGHT     = 20,
  parameter int TLAST_MODE = TLAST_FRAME
) (
  input  logic             ACLK,
  input  logic             aresetn,
  axis_pixel_gen_if.slave  s_axis,
  axis_pixel_gen_if.master m_axis,
  output logic             frame_done
);

  // tlast of pixel (0,0) depends only on the frame geometry.
  localparam logic FIRST_TLAST = (TLAST_MODE == TLAST_ROW) ? (WIDTH == 1)
                                 : ((WIDTH == 1) && (HEIGHT == 1));

  state_e                state_q, state_d;
  logic                  s_tready_q, s_tready_d;
  logic                  m_tvalid_q, m_tvalid_d;
  logic [DATA_WIDTH-1:0] m_tdata_q,  m_tdata_d;
  logic                  m_tlast_q,  m_tlast_d;
  logic                  m_tuser_q,  m_tuser_d;
  logic                  frame_done_q, frame_done_d;

  logic s_hs;
  logic m_hs;
  logic frame_end;
  logic row_end_nxt;
  logic frame_end_nxt;
  logic unused_sigs;
  logic unused_row_end;

  // s_tready is only ever high in IDLE, so s_hs doubles as "start a frame".
  assign s_hs = s_tready_q && s_axis.tvalid;
  assign m_hs = m_tvalid_q && m_axis.tready;

  axis_xy_counter #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT)
  ) u_xy (
    .ACLK          (ACLK),
    .aresetn       (aresetn),
    .clear         (s_hs),
    .en            (m_hs),
    .row_end       (unused_row_end),
    .frame_end     (frame_end),
    .row_end_nxt   (row_end_nxt),
    .frame_end_nxt (frame_end_nxt)
  );

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge ACLK) begin
    if (!aresetn) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (s_hs)              state_d = ST_STREAM;
      ST_STREAM: if (m_hs && frame_end) state_d = ST_IDLE;
      default:                          state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs (next values of the output flops)
  // ---------------------------------------------------------------------------
  always_comb begin
    // Handshake flags follow the state being entered, so they change in the
    // same cycle as the state itself.
    s_tready_d   = (state_d == ST_IDLE);
    m_tvalid_d   = (state_d == ST_STREAM);
    // Pixel fields hold unless a handshake moves them on; this keeps them
    // stable while the consumer stalls.
    m_tdata_d    = m_tdata_q;
    m_tlast_d    = m_tlast_q;
    m_tuser_d    = m_tuser_q;
    frame_done_d = 1'b0;

    if (s_hs) begin
      m_tdata_d = s_axis.tdata;
      m_tuser_d = 1'b1;
      m_tlast_d = FIRST_TLAST;
    end else if (m_hs) begin
      m_tuser_d = 1'b0;
      if (frame_end) begin
        m_tlast_d    = 1'b0;
        frame_done_d = 1'b1;
      end else begin
        m_tdata_d = m_tdata_q + 1'b1;
        m_tlast_d = (TLAST_MODE == TLAST_ROW) ? row_end_nxt : frame_end_nxt;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge ACLK) begin
    if (!aresetn) begin
      s_tready_q   <= 1'b0;
      m_tvalid_q   <= 1'b0;
      m_tdata_q    <= '0;
      m_tlast_q    <= 1'b0;
      m_tuser_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      s_tready_q   <= s_tready_d;
      m_tvalid_q   <= m_tvalid_d;
      m_tdata_q    <= m_tdata_d;
      m_tlast_q    <= m_tlast_d;
      m_tuser_q    <= m_tuser_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign s_axis.tready = s_tready_q;
  assign m_axis.tvalid = m_tvalid_q;
  assign m_axis.tdata  = m_tdata_q;
  assign m_axis.tlast  = m_tlast_q;
  assign m_axis.tuser  = m_tuser_q;
  assign frame_done    = frame_done_q;

  // The base-value stream carries no framing information for this block.
  assign unused_sigs = s_axis.tlast ^ s_axis.tuser ^ unused_row_end;

endmodule : axis_pixel_gen

// File: tb/tb_axis_pixel_gen.sv
// -----------------------------------------------------------------------------
// tb_axis_pixel_gen
//   Four generator instances with different geometries share clock and reset:
//     d0: 32-bit, 4x2, tlast per frame     d1: 32-bit, 4x2, tlast per row
//     d2:  8-bit, 4x1, tlast per frame     d3: 32-bit, 1x1, tlast per row
//   A frame-level model (busy flag, beat index, base) predicts every output
//   each cycle: pixel k of a frame is base+k, tuser on k==0, tlast by mode.
//   Directed frames pin the model with literal values, then random traffic.
// -----------------------------------------------------------------------------
module tb_axis_pixel_gen;

  localparam int N_DUT = 4;

  int cfg_w   [N_DUT] = '{4, 4, 4, 1};
  int cfg_h   [N_DUT] = '{2, 2, 1, 1};
  int cfg_mode[N_DUT] = '{0, 1, 0, 1};
  int cfg_dw  [N_DUT] = '{32, 32, 8, 32};

  logic ACLK;
  logic aresetn;

  logic        s_valid[N_DUT];
  logic [31:0] s_data [N_DUT];
  logic        m_ready[N_DUT];

  logic [31:0] o_data  [N_DUT];
  logic        o_valid [N_DUT];
  logic        o_last  [N_DUT];
  logic        o_user  [N_DUT];
  logic        o_sready[N_DUT];
  logic        o_done  [N_DUT];

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  bit run_cmp  = 0;

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;
  always @(posedge ACLK) cyc <= cyc + 1;

  // ---------------------------------------------------------------------------
  // DUTs
  // ---------------------------------------------------------------------------
  axis_pixel_gen_if #(.DATA_WIDTH(32)) s_if0 (), m_if0 ();
  axis_pixel_gen_if #(.DATA_WIDTH(32)) s_if1 (), m_if1 ();
  axis_pixel_gen_if #(.DATA_WIDTH(8))  s_if2 (), m_if2 ();
  axis_pixel_gen_if #(.DATA_WIDTH(32)) s_if3 (), m_if3 ();

  axis_pixel_gen #(.DATA_WIDTH(32), .WIDTH(4), .HEIGHT(2), .TLAST_MODE(0)) d0 (
    .ACLK(ACLK), .aresetn(aresetn), .s_axis(s_if0), .m_axis(m_if0), .frame_done(o_done[0]));
  axis_pixel_gen #(.DATA_WIDTH(32), .WIDTH(4), .HEIGHT(2), .TLAST_MODE(1)) d1 (
    .ACLK(ACLK), .aresetn(aresetn), .s_axis(s_if1), .m_axis(m_if1), .frame_done(o_done[1]));
  axis_pixel_gen #(.DATA_WIDTH(8),  .WIDTH(4), .HEIGHT(1), .TLAST_MODE(0)) d2 (
    .ACLK(ACLK), .aresetn(aresetn), .s_axis(s_if2), .m_axis(m_if2), .frame_done(o_done[2]));
  axis_pixel_gen #(.DATA_WIDTH(32), .WIDTH(1), .HEIGHT(1), .TLAST_MODE(1)) d3 (
    .ACLK(ACLK), .aresetn(aresetn), .s_axis(s_if3), .m_axis(m_if3), .frame_done(o_done[3]));

  assign s_if0.tdata = s_data[0];       assign s_if1.tdata = s_data[1];
  assign s_if2.tdata = s_data[2][7:0];  assign s_if3.tdata = s_data[3];
  assign s_if0.tvalid = s_valid[0];     assign s_if1.tvalid = s_valid[1];
  assign s_if2.tvalid = s_valid[2];     assign s_if3.tvalid = s_valid[3];
  assign s_if0.tlast = 1'b0;  assign s_if1.tlast = 1'b0;
  assign s_if2.tlast = 1'b0;  assign s_if3.tlast = 1'b0;
  assign s_if0.tuser = 1'b0;  assign s_if1.tuser = 1'b0;
  assign s_if2.tuser = 1'b0;  assign s_if3.tuser = 1'b0;
  assign m_if0.tready = m_ready[0];     assign m_if1.tready = m_ready[1];
  assign m_if2.tready = m_ready[2];     assign m_if3.tready = m_ready[3];

  assign o_data[0] = m_if0.tdata;          assign o_data[1] = m_if1.tdata;
  assign o_data[2] = {24'd0, m_if2.tdata}; assign o_data[3] = m_if3.tdata;
  assign o_valid[0] = m_if0.tvalid;  assign o_valid[1] = m_if1.tvalid;
  assign o_valid[2] = m_if2.tvalid;  assign o_valid[3] = m_if3.tvalid;
  assign o_last[0] = m_if0.tlast;    assign o_last[1] = m_if1.tlast;
  assign o_last[2] = m_if2.tlast;    assign o_last[3] = m_if3.tlast;
  assign o_user[0] = m_if0.tuser;    assign o_user[1] = m_if1.tuser;
  assign o_user[2] = m_if2.tuser;    assign o_user[3] = m_if3.tuser;
  assign o_sready[0] = s_if0.tready; assign o_sready[1] = s_if1.tready;
  assign o_sready[2] = s_if2.tready; assign o_sready[3] = s_if3.tready;

  // ---------------------------------------------------------------------------
  // Check helper
  // ---------------------------------------------------------------------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mask_of(input int dw);
    if (dw >= 32) return 32'hFFFF_FFFF;
    return (32'd1 << dw) - 32'd1;
  endfunction

  // ---------------------------------------------------------------------------
  // Frame-level reference model: a frame is N = W*H beats numbered k; the
  // beat index advances once per accepted pixel.
  // ---------------------------------------------------------------------------
  bit          mdl_busy[N_DUT] = '{default: 1'b0};
  int          mdl_idx [N_DUT] = '{default: 0};
  logic [31:0] mdl_base[N_DUT] = '{default: 32'd0};
  bit          mdl_rdy [N_DUT] = '{default: 1'b0};
  bit          mdl_done[N_DUT] = '{default: 1'b0};
  bit          mdl_rst = 1'b1;

  always @(posedge ACLK) begin
    for (int i = 0; i < N_DUT; i++) begin
      bit          nb;
      bit          nd;
      int          ni;
      logic [31:0] nbase;
      nb = mdl_busy[i]; ni = mdl_idx[i]; nbase = mdl_base[i]; nd = 1'b0;
      if (!aresetn) begin
        nb = 1'b0; ni = 0;
      end else if (nb) begin
        if (m_ready[i]) begin
          if (ni == cfg_w[i] * cfg_h[i] - 1) begin nb = 1'b0; nd = 1'b1; end
          else ni = ni + 1;
        end
      end else if (mdl_rdy[i] && s_valid[i]) begin
        nb = 1'b1; ni = 0; nbase = s_data[i] & mask_of(cfg_dw[i]);
      end
      mdl_busy[i] <= nb;
      mdl_idx[i]  <= ni;
      mdl_base[i] <= nbase;
      mdl_done[i] <= nd;
      mdl_rdy[i]  <= aresetn && !nb;
    end
    mdl_rst <= !aresetn;
  end

  // Compare every cycle, mid-period.
  always @(negedge ACLK) begin
    if (run_cmp) begin
      for (int i = 0; i < N_DUT; i++) begin
        int k;
        k = mdl_idx[i];
        check($sformatf("d%0d.s_tready", i), o_sready[i], mdl_rdy[i]);
        check($sformatf("d%0d.m_tvalid", i), o_valid[i], mdl_busy[i]);
        check($sformatf("d%0d.frame_done", i), o_done[i], mdl_done[i]);
        if (mdl_busy[i]) begin
          check($sformatf("d%0d.tdata", i), o_data[i],
                (mdl_base[i] + 32'(k)) & mask_of(cfg_dw[i]));
          check($sformatf("d%0d.tuser", i), o_user[i], k == 0);
          if (cfg_mode[i] == 0)
            check($sformatf("d%0d.tlast", i), o_last[i], k == cfg_w[i] * cfg_h[i] - 1);
          else
            check($sformatf("d%0d.tlast", i), o_last[i], (k % cfg_w[i]) == cfg_w[i] - 1);
        end
        if (mdl_rst) begin
          check($sformatf("d%0d.rst_tdata", i), o_data[i], 32'd0);
          check($sformatf("d%0d.rst_tlast", i), o_last[i], 1'b0);
          check($sformatf("d%0d.rst_tuser", i), o_user[i], 1'b0);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Beat / done logger for the literal checks
  // ---------------------------------------------------------------------------
  typedef struct {
    int          inst;
    logic [31:0] data;
    bit          last;
    bit          user;
    int          cyc;
  } beat_t;

  beat_t beats[$];
  int    dones_inst[$];
  int    dones_cyc [$];

  always @(negedge ACLK) begin
    for (int i = 0; i < N_DUT; i++) begin
      if (o_valid[i] === 1'b1 && m_ready[i]) begin
        beat_t b;
        b.inst = i; b.data = o_data[i]; b.last = o_last[i]; b.user = o_user[i]; b.cyc = cyc;
        beats.push_back(b);
      end
      if (o_done[i] === 1'b1) begin
        dones_inst.push_back(i);
        dones_cyc.push_back(cyc);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (inputs change #1 after the rising edge)
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  // Present s_data on the selected instances until each one is accepted.
  task automatic launch(input bit [N_DUT-1:0] sel);
    bit [N_DUT-1:0] pend;
    pend = sel;
    for (int i = 0; i < N_DUT; i++) s_valid[i] = sel[i];
    for (int c = 0; c < 50 && pend != '0; c++) begin
      bit [N_DUT-1:0] hs;
      hs = '0;
      for (int i = 0; i < N_DUT; i++) if (pend[i] && o_sready[i]) hs[i] = 1'b1;
      tick();
      for (int i = 0; i < N_DUT; i++) if (hs[i]) begin s_valid[i] = 1'b0; pend[i] = 1'b0; end
    end
    check("launch_timeout", {28'd0, pend}, 32'd0);
  endtask

  task automatic wait_idle(input int max_cyc);
    bit any;
    int c;
    c = 0;
    any = o_valid[0] || o_valid[1] || o_valid[2] || o_valid[3];
    while (any && c < max_cyc) begin
      tick();
      c++;
      any = o_valid[0] || o_valid[1] || o_valid[2] || o_valid[3];
    end
    check("idle_timeout", {31'd0, any}, 32'd0);
    tick();
    tick();
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    int          cnt[N_DUT];
    int          last_cyc0;
    int          n_done0;
    int          done_cyc0;
    int          n102;
    bit          stalled;
    logic [31:0] d2_exp[4];

    d2_exp = '{32'hFE, 32'hFF, 32'h00, 32'h01};
    aresetn = 1'b0;
    for (int i = 0; i < N_DUT; i++) begin
      s_valid[i] = 1'b0; s_data[i] = 32'd0; m_ready[i] = 1'b1;
    end

    // Reset state
    tick();
    run_cmp = 1'b1;
    tick();
    check("rst.s_tready", o_sready[0], 1'b0);
    check("rst.m_tvalid", o_valid[0], 1'b0);
    check("rst.tdata", o_data[0], 32'd0);
    check("rst.frame_done", o_done[0], 1'b0);
    aresetn = 1'b1;
    tick();
    check("rel.s_tready", o_sready[0], 1'b1);
    check("rel.m_tvalid", o_valid[0], 1'b0);

    // Phase A: one frame per instance at full rate
    beats.delete(); dones_inst.delete(); dones_cyc.delete();
    s_data[0] = 32'd100; s_data[1] = 32'd100; s_data[2] = 32'hFE; s_data[3] = 32'd7;
    launch(4'b1111);
    check("A.first_tvalid", o_valid[0], 1'b1);
    check("A.s_tready_low", o_sready[0], 1'b0);
    wait_idle(40);

    cnt = '{default: 0};
    last_cyc0 = -100;
    foreach (beats[j]) begin
      int i;
      int k;
      i = beats[j].inst;
      k = cnt[i];
      case (i)
        0: begin
          check("A.d0.data", beats[j].data, 32'(100 + k));
          check("A.d0.user", beats[j].user, k == 0);
          check("A.d0.last", beats[j].last, k == 7);
          if (k == 7) last_cyc0 = beats[j].cyc;
        end
        1: begin
          check("A.d1.data", beats[j].data, 32'(100 + k));
          check("A.d1.last", beats[j].last, (k == 3) || (k == 7));
        end
        2: check("A.d2.data", beats[j].data, d2_exp[k & 3]);
        default: begin
          check("A.d3.data", beats[j].data, 32'd7);
          check("A.d3.user", beats[j].user, 1'b1);
          check("A.d3.last", beats[j].last, 1'b1);
        end
      endcase
      cnt[i] = cnt[i] + 1;
    end
    check("A.d0.beats", cnt[0], 8);
    check("A.d1.beats", cnt[1], 8);
    check("A.d2.beats", cnt[2], 4);
    check("A.d3.beats", cnt[3], 1);
    n_done0 = 0;
    done_cyc0 = -1;
    foreach (dones_inst[j]) if (dones_inst[j] == 0) begin n_done0++; done_cyc0 = dones_cyc[j]; end
    check("A.d0.done_count", n_done0, 1);
    check("A.d0.done_latency", done_cyc0 - last_cyc0, 1);

    // Phase B: consumer stalls for 3 cycles while pixel 102 is presented
    beats.delete();
    s_data[0] = 32'd100;
    launch(4'b0001);
    stalled = 1'b0;
    for (int c = 0; c < 20 && !stalled; c++) begin
      if (o_valid[0] && o_data[0] == 32'd102) begin
        stalled = 1'b1;
        m_ready[0] = 1'b0;
        for (int k = 0; k < 3; k++) begin
          tick();
          check("B.stall_tvalid", o_valid[0], 1'b1);
          check("B.stall_tdata", o_data[0], 32'd102);
        end
        m_ready[0] = 1'b1;
      end else begin
        tick();
      end
    end
    check("B.stall_seen", stalled, 1'b1);
    wait_idle(40);
    n102 = 0;
    foreach (beats[j]) if (beats[j].inst == 0 && beats[j].data == 32'd102) n102++;
    check("B.beats_102", n102, 1);

    // Phase C: reset after three of eight pixels, then a new frame
    s_data[0] = 32'd300;
    launch(4'b0001);
    tick(); tick(); tick();
    dones_inst.delete(); dones_cyc.delete();
    aresetn = 1'b0;
    tick();
    check("C.tvalid_after_rst", o_valid[0], 1'b0);
    check("C.s_tready_in_rst", o_sready[0], 1'b0);
    tick();
    aresetn = 1'b1;
    tick();
    check("C.s_tready_after_rel", o_sready[0], 1'b1);
    tick();
    check("C.no_frame_done", dones_inst.size(), 0);
    check("C.still_idle", o_valid[0], 1'b0);
    s_data[0] = 32'd200;
    launch(4'b0001);
    check("C.new_tvalid", o_valid[0], 1'b1);
    check("C.new_tdata", o_data[0], 32'd200);
    check("C.new_tuser", o_user[0], 1'b1);
    wait_idle(40);

    // Phase D: random traffic against the model
    for (int c = 0; c < 4000; c++) begin
      aresetn = ($urandom_range(0, 599) != 0);
      for (int i = 0; i < N_DUT; i++) begin
        m_ready[i] = ($urandom_range(0, 3) != 0);
        s_valid[i] = ($urandom_range(0, 5) == 0);
        s_data[i]  = $urandom;
      end
      tick();
    end
    aresetn = 1'b1;
    for (int i = 0; i < N_DUT; i++) begin s_valid[i] = 1'b0; m_ready[i] = 1'b1; end
    wait_idle(60);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_axis_pixel_gen
